// File: rtl/dma_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_fifo_pkg
//  Purpose  : Shared constants and helpers for the DMA data-path FIFO.
//             Holds the default word width / depth used by the DMA
//             controller, the clog2 helper, pointer/count width derivation
//             and the parameter legality predicate.
//  Revision : 1.0 - initial multi-entry FIFO release
// ============================================================================
package dma_fifo_pkg;

    // Defaults shared with the DMA controller.
    localparam int c_def_data_w = 16;
    localparam int c_def_depth  = 8;

    // Ceiling log2 for elaboration-time width derivation (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Pointer width: wraps naturally from DEPTH-1 to 0.
    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    // Count width: one extra bit so the value DEPTH is representable.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    // DEPTH must be a power of two >= 2 and both thresholds in range.
    function automatic bit params_legal(input int depth, input int afull_thr,
                                        input int aempty_thr);
        return (depth >= 2) &&
               ((depth & (depth - 1)) == 0) &&
               (afull_thr >= 1) && (afull_thr <= depth) &&
               (aempty_thr >= 0) && (aempty_thr <= depth - 1);
    endfunction

endpackage : dma_fifo_pkg
`default_nettype wire

// File: rtl/dma_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : dma_fifo_mem
//  Purpose  : DEPTH x DATA_W storage array for the DMA FIFO. One synchronous
//             write port and one registered read port. Contents are never
//             cleared; only the read output register is reset.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             wr_en/addr/data - write port (written on rising edge)
//             rd_en/addr      - read request; rd_data loads on rising edge
//             rd_data         - output register, holds between reads
//  Revision : 1.0 - initial release
// ============================================================================
module dma_fifo_mem
    import dma_fifo_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int DEPTH  = c_def_depth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ptr_w(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [ptr_w(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its last value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : dma_fifo_mem
`default_nettype wire

// File: rtl/dma_fifo_synch.sv
`default_nettype none
// ============================================================================
//  Module   : dma_fifo_synch
//  Purpose  : Parametrised synchronous FIFO for the DMA data path. Buffers
//             DATA_W-bit words between the bus-side reader and the
//             peripheral-side writer, with 1-cycle registered read latency.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             flush             - synchronous discard of all contents
//             wr_en, wr_data    - write request / word
//             rd_en             - read request
//             rd_data, rd_valid - registered read word, 1-cycle valid pulse
//             full, empty, almost_full, almost_empty, count - status
//             overflow, underflow - sticky error flags, cleared by clr_err
//  Revision : 1.0 - multi-entry successor of the single-register stage
// ============================================================================
module dma_fifo_synch
    import dma_fifo_pkg::*;
#(
    parameter int DATA_W     = c_def_data_w,
    parameter int DEPTH      = c_def_depth,
    parameter int AFULL_THR  = 6,
    parameter int AEMPTY_THR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int c_ptr_w = ptr_w(DEPTH);
    localparam int c_cnt_w = cnt_w(DEPTH);

    localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_afull_thr  = c_cnt_w'(AFULL_THR);
    localparam logic [c_cnt_w-1:0] c_aempty_thr = c_cnt_w'(AEMPTY_THR);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

    if (!params_legal(DEPTH, AFULL_THR, AEMPTY_THR)) begin : g_param_check
        $error("dma_fifo_synch: DEPTH must be a power of two >= 2 and thresholds in range");
    end

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_rd_valid;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [c_cnt_w-1:0] w_count_next;

    // Status is a pure decode of the registered count.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // Acceptance uses pre-edge status. rst and flush suppress both ports so
    // the memory is never written and the output register never reloads.
    assign w_wr_acc = wr_en & ~w_full  & ~flush & ~rst;
    assign w_rd_acc = rd_en & ~w_empty & ~flush & ~rst;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count    <= w_count_next;
            r_rd_valid <= w_rd_acc;
        end
    end

    // Sticky error flags: a new error wins over a same-cycle clear; a flush
    // cycle leaves the flags untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!flush) begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    dma_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_ptr),
        .rd_data (rd_data)
    );

    assign rd_valid     = r_rd_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_afull_thr);
    assign almost_empty = (r_count <= c_aempty_thr);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : dma_fifo_synch
`default_nettype wire

// File: tb/tb_dma_fifo_synch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_fifo_synch
//  Purpose  : Self-checking bench for dma_fifo_synch. A queue-based model
//             tracks contents and flags; directed sequences pin literal
//             values, followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_fifo_synch;

    localparam int DATA_W     = 16;
    localparam int DEPTH      = 8;
    localparam int AFULL_THR  = 6;
    localparam int AEMPTY_THR = 2;
    localparam int CNT_W      = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    always #5 clk = ~clk;

    dma_fifo_synch #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .AFULL_THR  (AFULL_THR),
        .AEMPTY_THR (AEMPTY_THR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_q[$];
    logic              m_rv  = 1'b0;
    logic [DATA_W-1:0] m_rd  = '0;
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;
    bit                chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_rv  = 1'b0;
            m_rd  = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (flush) begin
            m_q.delete();
            m_rv = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            m_rv = 1'b0;
            if (rd_en && !was_empty) begin
                m_rd = m_q.pop_front();
                m_rv = 1'b1;
            end
            if (wr_en && !was_full) m_q.push_back(wr_data);
            if (wr_en && was_full) m_ovf = 1'b1;
            else if (clr_err)      m_ovf = 1'b0;
            if (rd_en && was_empty) m_unf = 1'b1;
            else if (clr_err)       m_unf = 1'b0;
        end
    end

    // Compare process: every cycle once the first reset has taken effect.
    always @(negedge clk) begin
        int c;
        if (chk_en) begin
            c = m_q.size();
            check("count",        32'(count),        32'(c));
            check("full",         32'(full),         32'(c == DEPTH));
            check("empty",        32'(empty),        32'(c == 0));
            check("almost_full",  32'(almost_full),  32'(c >= AFULL_THR));
            check("almost_empty", 32'(almost_empty), 32'(c <= AEMPTY_THR));
            check("rd_valid",     32'(rd_valid),     32'(m_rv));
            check("rd_data",      32'(rd_data),      32'(m_rd));
            check("overflow",     32'(overflow),     32'(m_ovf));
            check("underflow",    32'(underflow),    32'(m_unf));
        end
    end

    // One clock: drive inputs now (just after a falling edge), return at the
    // next falling edge when the post-edge outputs are settled.
    task automatic step(input logic w, input logic [DATA_W-1:0] wd, input logic r,
                        input logic fl, input logic ce, input logic rs);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        flush   = fl;
        clr_err = ce;
        rst     = rs;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        // Reset values
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);

        // 1: fill with 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            step(1, DATA_W'(i), 0, 0, 0, 0);
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), 32'(i >= 6));
            check("fill_full", 32'(full), 32'(i == 8));
        end
        check("fill_empty", 32'(empty), 0);
        check("fill_ovf", 32'(overflow), 0);

        // 2: drain in order, then one read too many
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 0, 0, 0);
            check("drain_rv", 32'(rd_valid), 1);
            check("drain_data", 32'(rd_data), 32'(i));
            check("drain_count", 32'(count), 32'(8 - i));
        end
        check("drain_empty", 32'(empty), 1);
        step(0, 0, 1, 0, 0, 0);
        check("unf_set", 32'(underflow), 1);
        check("unf_rd_data", 32'(rd_data), 32'h0008);
        check("unf_rv", 32'(rd_valid), 0);
        step(0, 0, 0, 0, 1, 0);
        check("unf_clr", 32'(underflow), 0);

        // 3: write+read while full
        for (int i = 0; i < 8; i++) step(1, DATA_W'(16'h0011 + i), 0, 0, 0, 0);
        check("f3_full", 32'(full), 1);
        step(1, 16'hAAAA, 1, 0, 0, 0);
        check("f3_rd_data", 32'(rd_data), 32'h0011);
        check("f3_rv", 32'(rd_valid), 1);
        check("f3_ovf", 32'(overflow), 1);
        check("f3_count", 32'(count), 7);
        step(0, 0, 0, 0, 1, 0);
        check("f3_ovf_clr", 32'(overflow), 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0, 0, 0);
            check("f3_drain", 32'(rd_data), 32'(16'h0012 + i));
        end
        check("f3_empty", 32'(empty), 1);

        // 4: steady stream at count=4 across pointer wrap
        for (int i = 0; i < 4; i++) step(1, DATA_W'(16'h0100 + i), 0, 0, 0, 0);
        for (int j = 0; j < 20; j++) begin
            step(1, DATA_W'(16'h0104 + j), 1, 0, 0, 0);
            check("s4_count", 32'(count), 4);
            check("s4_data", 32'(rd_data), 32'(16'h0100 + j));
        end

        // 5: flush with simultaneous wr/rd at count=5
        step(1, 16'h0118, 0, 0, 0, 0);
        check("f5_count", 32'(count), 5);
        step(1, 16'h5555, 1, 1, 0, 0);
        check("f5_count0", 32'(count), 0);
        check("f5_empty", 32'(empty), 1);
        check("f5_rv", 32'(rd_valid), 0);
        check("f5_ovf", 32'(overflow), 0);
        check("f5_unf", 32'(underflow), 0);
        check("f5_rd_data", 32'(rd_data), 32'h0113);

        // 6: reset mid-stream with a read in flight
        for (int i = 0; i < 3; i++) step(1, DATA_W'(16'h0021 + i), 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("r6_data", 32'(rd_data), 32'h0021);
        check("r6_rv", 32'(rd_valid), 1);
        step(0, 0, 1, 0, 0, 1);
        check("r6_count", 32'(count), 0);
        check("r6_rv0", 32'(rd_valid), 0);
        check("r6_rd_data0", 32'(rd_data), 0);
        check("r6_empty", 32'(empty), 1);
        step(1, 16'h1234, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("r6_data2", 32'(rd_data), 32'h1234);
        check("r6_rv2", 32'(rd_valid), 1);

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int k = 0; k < 3000; k++) begin
            int wp;
            logic w, r, fl, ce, rs;
            wp = ((k / 150) % 2 == 0) ? 75 : 25;
            w  = ($urandom_range(0, 99) < wp);
            r  = ($urandom_range(0, 99) < (100 - wp));
            fl = ($urandom_range(0, 59) == 0);
            ce = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 499) == 0);
            step(w, DATA_W'($urandom), r, fl, ce, rs);
        end

        step(0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dma_fifo_synch
`default_nettype wire

// File: doc/dma_fifo_synch.md
Name: dma_fifo_synch

Overview:
- Parametrised synchronous FIFO for the DMA controller data path. It is the multi-entry successor of the single-register transfer stage.
- Buffers DATA_W-bit words between the bus-side reader and the peripheral-side writer.
- Provides full/empty/almost status, an occupancy count, a registered read port with a valid strobe, flush, and sticky overflow/underflow error flags.

Parameters:
DATA_W, 16, word width in bits
DEPTH, 8, number of entries; power of two, >= 2
AFULL_THR, 6, almost_full asserts when count >= AFULL_THR (1..DEPTH)
AEMPTY_THR, 2, almost_empty asserts when count <= AEMPTY_THR (0..DEPTH-1)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous discard of all contents
wr_en  in  1  write request
wr_data  in  DATA_W  write word
rd_en  in  1  read request
rd_data  out  DATA_W  registered read word
rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THR
almost_empty  out  1  count <= AEMPTY_THR
count  out  CNT_W  occupancy, CNT_W = clog2(DEPTH)+1
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at edge):
  - wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow and underflow all go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (given AFULL_THR>=1).
  - Memory contents are not cleared.
  - rst overrides all other inputs.
- Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked separately.
- Acceptance is evaluated on pre-edge state:
  - wr_acc = wr_en & !full
  - rd_acc = rd_en & !empty
- Write: if wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read latency is 1 cycle. If rd_acc, on that edge rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 for exactly that following cycle.
  - Otherwise rd_valid=0 and rd_data holds its last value. It is never driven to Z.
- count update:
  - +1 if wr_acc only
  - -1 if rd_acc only
  - unchanged if both or neither
- Status outputs are combinational decodes of the registered count, so they are valid the cycle after the causing edge.
- Simultaneous wr_en & rd_en:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: the read is accepted, the write is rejected, overflow is set, count goes to DEPTH-1. There is no pass-through.
  - Empty: the write is accepted, the read is rejected, underflow is set, count goes to 1. There is no bypass; the word is readable from the next cycle.
- Errors:
  - overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty.
  - Both hold until clr_err or rst. A same-cycle set has priority over clr_err.
- flush (rst=0):
  - Pointers and count go to 0, and rd_valid=0 next cycle.
  - wr_en and rd_en in the same cycle are ignored and do not raise error flags.
  - rd_data and the error flags are unchanged.
- Invariant: count <= DEPTH at all times, and wr_ptr - rd_ptr (mod DEPTH) == count mod DEPTH.

Decomposition:
- Package dma_fifo_pkg holds:
  - the clog2 helper function and CNT_W/PTR_W derivation
  - default DATA_W/DEPTH constants shared with the DMA controller
  - a parameter legality check that fails elaboration if DEPTH is not a power of two or a threshold is out of range
- One sub-module, dma_fifo_mem: a DEPTH x DATA_W array with one synchronous write port and one registered read port (read enable, output register). The top level keeps pointers, count, flags and handshake logic.

Test Plan:
1. Reset, then write 0x0001..0x0008 on consecutive cycles (DEPTH=8) -> count steps 1..8; almost_full from count 6; full=1 after the 8th; empty=0; no errors.
2. From full, read 8 times -> rd_data 0x0001..0x0008 in order, each one cycle after its rd_en with rd_valid pulsing; count reaches 0, empty=1; a further rd_en sets underflow=1 and leaves rd_data=0x0008.
3. Full FIFO with simultaneous wr_en(0xAAAA) & rd_en -> oldest word is read, 0xAAAA is dropped, overflow=1, count=7. Then clr_err -> overflow=0.
4. Steady stream: 20 cycles of simultaneous rd/wr at count=4 -> count stays 4; output order equals input order across pointer wrap.
5. Count=5, flush asserted together with wr_en & rd_en -> next cycle count=0, empty=1, rd_valid=0, no error flags, rd_data unchanged.
6. Mid-stream rst with count=3 and an rd_valid pulse pending -> next cycle all outputs at reset values; a subsequent write of 0x1234 then a read returns 0x1234.
